// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - funct field codes for the muldiv instruction class
//   - FSM state encoding used by muldivunit
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldivcore.sv
// muldivcore: one-bit-per-step datapath for unsigned multiply and divide.
//   load   : capture operand magnitudes a (multiplier/dividend), b (multiplicand/divisor)
//   step   : perform one iteration (shift-add or restoring shift-subtract)
//   is_div : selects divide iteration when set, multiply otherwise
//   prod   : 2*DWIDTH product after DWIDTH steps
//   quot   : quotient after DWIDTH divide steps
//   rem    : remainder after DWIDTH divide steps
module muldivcore #(
  parameter int DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DWIDTH-1:0]     a,
  input  logic [DWIDTH-1:0]     b,
  output logic [2*DWIDTH-1:0]   prod,
  output logic [DWIDTH-1:0]     quot,
  output logic [DWIDTH-1:0]     rem
);

  // Multiply uses all of acc_r; divide keeps the quotient (shifting in) in the low half.
  logic [2*DWIDTH-1:0] acc_r;
  logic [DWIDTH:0]     rem_r;
  logic [DWIDTH-1:0]   b_r;

  logic [DWIDTH:0]     mul_sum_s;
  logic [DWIDTH:0]     div_shift_s;
  logic                div_ge_s;

  // One iteration's arithmetic: partial-product add and trial subtraction compare
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*DWIDTH-1:DWIDTH]};
    div_shift_s = {rem_r[DWIDTH-1:0], acc_r[DWIDTH-1]};
    div_ge_s    = 1'b0;
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*DWIDTH-1:DWIDTH]} + {1'b0, b_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*DWIDTH-1:DWIDTH]};
    end
    if (div_shift_s >= {1'b0, b_r}) begin
      div_ge_s = 1'b1;
    end else begin
      div_ge_s = 1'b0;
    end
  end

  // Iteration registers: load operands, then advance one bit per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      rem_r <= '0;
      b_r   <= '0;
    end else if (load) begin
      acc_r <= {{DWIDTH{1'b0}}, a};
      rem_r <= '0;
      b_r   <= b;
    end else if (step) begin
      if (is_div) begin
        if (div_ge_s) begin
          rem_r <= div_shift_s - {1'b0, b_r};
          acc_r <= {acc_r[2*DWIDTH-1:DWIDTH], acc_r[DWIDTH-2:0], 1'b1};
        end else begin
          rem_r <= div_shift_s;
          acc_r <= {acc_r[2*DWIDTH-1:DWIDTH], acc_r[DWIDTH-2:0], 1'b0};
        end
      end else begin
        acc_r <= {mul_sum_s, acc_r[DWIDTH-1:1]};
      end
    end
  end

  assign prod = acc_r;
  assign quot = acc_r[DWIDTH-1:0];
  assign rem  = rem_r[DWIDTH-1:0];

endmodule

// File: rtl/muldivunit.sv
// muldivunit: EX-stage iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//   start/functin/opa/opb : instruction from ID/EX (funct codes in muldiv_pkg)
//   flush                 : squash in-flight operation, blocks acceptance in IDLE
//   busy                  : registered stall request while an op is in flight
//   done                  : one-cycle pulse after HI/LO take a MULT/DIV result
//   hi/lo                 : architectural HI/LO registers
module muldivunit
  import muldiv_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        functin,
  input  logic [DWIDTH-1:0] opa,
  input  logic [DWIDTH-1:0] opb,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] hi,
  output logic [DWIDTH-1:0] lo
);

  localparam int CW = $clog2(DWIDTH);

  md_state_e           state_r, state_next_s;
  logic [CW-1:0]       cnt_r;
  logic                is_div_r, neg_res_r, neg_rem_r, dz_r;
  logic [DWIDTH-1:0]   hi_r, lo_r;
  logic                busy_r, done_r;

  logic                op_mul_s, op_div_s, op_signed_s;
  logic                idle_take_s, accept_s, wr_mthi_s, wr_mtlo_s;
  logic                a_neg_s, b_neg_s;
  logic [DWIDTH-1:0]   mag_a_s, mag_b_s;
  logic                step_s, fin_wr_s;
  logic [2*DWIDTH-1:0] prod_s, prod_fix_s;
  logic [DWIDTH-1:0]   quot_s, rem_s, res_hi_s, res_lo_s;

  // Decode the presented instruction and prepare operand magnitudes
  always_comb begin
    op_mul_s    = (functin == FN_MULT) || (functin == FN_MULTU);
    op_div_s    = (functin == FN_DIV)  || (functin == FN_DIVU);
    op_signed_s = (functin == FN_MULT) || (functin == FN_DIV);
    idle_take_s = (state_r == IDLE) && start && !flush;
    accept_s    = idle_take_s && (op_mul_s || op_div_s);
    wr_mthi_s   = idle_take_s && (functin == FN_MTHI);
    wr_mtlo_s   = idle_take_s && (functin == FN_MTLO);
    a_neg_s     = op_signed_s && opa[DWIDTH-1];
    b_neg_s     = op_signed_s && opb[DWIDTH-1];
    if (a_neg_s) begin
      mag_a_s = -opa;
    end else begin
      mag_a_s = opa;
    end
    if (b_neg_s) begin
      mag_b_s = -opb;
    end else begin
      mag_b_s = opb;
    end
  end

  // Next-state logic; flush dominates everything outside IDLE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          state_next_s = IDLE;
        end else if (cnt_r == CW'(DWIDTH-1)) begin
          state_next_s = FIN;
        end else begin
          state_next_s = CALC;
        end
      end
      FIN: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign step_s   = (state_r == CALC) && !flush;
  assign fin_wr_s = (state_r == FIN) && !flush;

  muldivcore #(.DWIDTH(DWIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept_s),
    .step   (step_s),
    .is_div (is_div_r),
    .a      (mag_a_s),
    .b      (mag_b_s),
    .prod   (prod_s),
    .quot   (quot_s),
    .rem    (rem_s)
  );

  // Sign correction of the unsigned core result.
  // Divide-by-zero leaves the quotient at all-ones; the remainder equals |opa|,
  // so restoring the dividend sign reproduces opa exactly in HI.
  always_comb begin
    prod_fix_s = prod_s;
    res_hi_s   = prod_s[2*DWIDTH-1:DWIDTH];
    res_lo_s   = prod_s[DWIDTH-1:0];
    if (is_div_r) begin
      if (dz_r) begin
        res_lo_s = {DWIDTH{1'b1}};
      end else if (neg_res_r) begin
        res_lo_s = -quot_s;
      end else begin
        res_lo_s = quot_s;
      end
      if (neg_rem_r) begin
        res_hi_s = -rem_s;
      end else begin
        res_hi_s = rem_s;
      end
    end else begin
      if (neg_res_r) begin
        prod_fix_s = -prod_s;
      end else begin
        prod_fix_s = prod_s;
      end
      res_hi_s = prod_fix_s[2*DWIDTH-1:DWIDTH];
      res_lo_s = prod_fix_s[DWIDTH-1:0];
    end
  end

  // FSM state, iteration counter and per-operation sign flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        cnt_r     <= '0;
        is_div_r  <= op_div_s;
        neg_res_r <= a_neg_s ^ b_neg_s;
        neg_rem_r <= a_neg_s;
        dz_r      <= op_div_s && (opb == '0);
      end else if (step_s) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Architectural HI/LO plus registered busy/done status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= fin_wr_s;
      if (fin_wr_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else begin
        if (wr_mthi_s) begin
          hi_r <= opa;
        end
        if (wr_mtlo_s) begin
          lo_r <= opa;
        end
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldivunit.sv
// tb_muldivunit: self-checking bench for muldivunit with directed corner cases
// and randomized operations compared against an arithmetic reference model.
module tb_muldivunit;
  import muldiv_pkg::*;

  logic        clk, rst_n, start, flush, busy, done;
  logic [5:0]  functin;
  logic [31:0] opa, opb, hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mh, ml;  // model HI/LO

  muldivunit #(.DWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .functin(functin),
    .opa(opa), .opb(opb), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: returns {hi,lo} after executing f on a,b given prior h,l
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h,
                                         input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      FN_MULT:  begin q = sa * sb; return q; end
      FN_MULTU: begin p = ua * ub; return p; end
      FN_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      FN_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        p = ua / ub; ua = ua % ub;
        return {ua[31:0], p[31:0]};
      end
      FN_MTHI: return {a, l};
      FN_MTLO: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  function automatic bit is_long(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  // Drive one instruction for one cycle (caller at a negedge)
  task automatic start_only(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; functin = f; opa = a; opb = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Issue an op and check timing and result; caller at a negedge, returns at a negedge
  task automatic exec_op(input string tag, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int lat, busy_n;
    bit stable;
    e = ref_op(f, a, b, mh, ml);
    start_only(f, a, b);
    if (!is_long(f)) begin
      @(negedge clk);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_hilo"}, {hi, lo}, e);
    end else begin
      lat = 0; busy_n = 0; stable = 1'b1;
      while (1) begin
        @(negedge clk);
        lat++;
        if (done || lat > 60) break;
        busy_n += busy;
        if (hi !== mh || lo !== ml) stable = 1'b0;
      end
      check({tag, "_latency"}, lat, 34);
      check({tag, "_busycyc"}, busy_n, 33);
      check({tag, "_stable"}, stable, 1'b1);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_hilo"}, {hi, lo}, e);
    end
    mh = e[63:32];
    ml = e[31:0];
  endtask

  initial begin
    logic [5:0]  fsel [7];
    logic [31:0] ra, rb;
    logic [63:0] e;
    fsel = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO, FN_MFHI};
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; functin = 6'd0; opa = 32'd0; opb = 32'd0;
    mh = 32'd0; ml = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    exec_op("mult_neg3x5", FN_MULT, 32'hFFFFFFFD, 32'd5);
    check("mult_neg3x5_hi", hi, 32'hFFFFFFFF);
    check("mult_neg3x5_lo", lo, 32'hFFFFFFF1);
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    exec_op("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    exec_op("div_m7_2", FN_DIV, 32'hFFFFFFF9, 32'd2);
    check("div_m7_2_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    exec_op("divu_by0", FN_DIVU, 32'd7, 32'd0);
    check("divu_by0_hilo", {hi, lo}, 64'h00000007_FFFFFFFF);
    exec_op("div_by0_neg", FN_DIV, 32'hFFFFFFF0, 32'd0);
    exec_op("div_ovf", FN_DIV, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);
    exec_op("mthi", FN_MTHI, 32'h1234, 32'd0);
    check("mthi_hi", hi, 32'h1234);
    exec_op("mtlo", FN_MTLO, 32'h5678, 32'd0);
    exec_op("unsupported", FN_MFHI, 32'hDEAD, 32'hBEEF);

    // Flush mid-operation, then a DIVU issued right after
    start_only(FN_MULT, 32'd1000, 32'd3000);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 1'b0);
    check("flush_done", done, 1'b0);
    check("flush_hilo", {hi, lo}, {mh, ml});
    exec_op("divu_after_flush", FN_DIVU, 32'd100, 32'd7);

    // flush and start together in IDLE: nothing accepted
    flush = 1'b1;
    start_only(FN_MULT, 32'd9, 32'd9);
    flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", busy, 1'b0);
    check("flush_start_hilo", {hi, lo}, {mh, ml});

    // Starts while busy are ignored
    e = ref_op(FN_MULTU, 32'd123456, 32'd654321, mh, ml);
    start_only(FN_MULTU, 32'd123456, 32'd654321);
    repeat (5) @(negedge clk);
    start_only(FN_MTLO, 32'hCAFE, 32'd0);
    @(negedge clk);
    check("mtlo_busy_lo", lo, ml);
    start_only(FN_DIV, 32'd50, 32'd5);
    repeat (60) begin
      @(negedge clk);
      if (done) break;
    end
    check("ignored_done", done, 1'b1);
    check("ignored_hilo", {hi, lo}, e);
    mh = e[63:32]; ml = e[31:0];
    @(negedge clk);
    check("ignored_no_second", busy, 1'b0);

    // Asynchronous reset mid-operation
    start_only(FN_MULT, 32'h7FFF0000, 32'h00012345);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    mh = 32'd0; ml = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exec_op("after_reset", FN_DIV, 32'hFFFFFF00, 32'd7);

    // Randomized operations (back-to-back, including the done cycle)
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = 32'd0; end
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: begin
          ra = 32'($signed($urandom_range(0, 200)) - 100);
          rb = 32'($signed($urandom_range(0, 20)) - 10);
        end
      endcase
      exec_op($sformatf("rand%0d", i), fsel[$urandom_range(0, 6)], ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldivunit.md
# muldivunit

Iterative EX-stage multiply/divide unit with architectural HI/LO registers, directly downstream of the ID/EX pipeline register. It takes the register-file operands and funct field that the ID/EX register presents and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO contents are exposed for MFHI/MFLO forwarding. While an operation is in flight it raises `busy` so hazard logic can stall the front of the pipeline.

## Interface
Parameters:
- DWIDTH, 32, operand/HI/LO width; the iteration count equals DWIDTH

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  ID/EX holds a valid muldiv-class instruction this cycle
- functin  in  6  funct field: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO; other codes ignored
- opa  in  DWIDTH  rs value (from regdata1out)
- opb  in  DWIDTH  rt value (from regdata2out)
- flush  in  1  abort in-flight operation (branch/jump squash)
- busy  out  1  operation in flight; stall request
- done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- hi  out  DWIDTH  HI register
- lo  out  DWIDTH  LO register

## Operation
- States: IDLE, CALC, FIN.
- IDLE, start=1, MULT/MULTU/DIV/DIVU: latch operand magnitudes (signed ops take absolute values and record result signs), clear the 5-bit counter, go to CALC.
- IDLE, start=1, MTHI/MTLO: write opa to hi/lo at that edge; remain IDLE; busy stays 0; no done.
- CALC: one bit per cycle.
  - Multiply: shift-add over a 2·DWIDTH accumulator.
  - Divide: restoring shift-subtract, remainder DWIDTH+1 bits.
  - After DWIDTH iterations (counter wraps 31→0), go to FIN.
- FIN: apply sign correction and write HI/LO, then return to IDLE with done=1 for one cycle.
  - Multiply: {HI,LO} = 64-bit product, negated if operand signs differ (signed op).
  - Divide: LO = quotient, HI = remainder. The quotient is negated if signs differ. The remainder takes the dividend's sign.
  - Overflow: 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - Divide by zero (signed or unsigned): HI=opa, LO=0xFFFFFFFF, with no sign correction and normal latency.
- start while busy=1 is ignored. Upstream must hold the instruction until busy=0.
- Unsupported functin with start=1 is ignored.
- flush=1 in CALC/FIN returns to IDLE at the next edge. HI/LO are unchanged and there is no done pulse.
- flush and start in the same IDLE cycle: flush wins and nothing is accepted.
- Asynchronous reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. This holds even mid-operation, and the aborted result is lost.

## Timing
- Start accepted at edge E0. busy=1 in the cycles after E0 through E33.
- E1..E32 perform the 32 iterations. E33 performs FIN and writes HI/LO.
- In the cycle after E33: busy=0, done=1, and hi/lo hold the new result.
- Total latency: 34 cycles from the accepting edge to visible HI/LO.
- busy is registered and has no combinational path from start. The hazard unit ORs `start & muldiv-class` itself if it needs to stall in the issue cycle.
- MTHI/MTLO: result visible one cycle after the accepting edge.
- hi/lo are direct register outputs and stable while busy=1. They hold the old values until E33.
- A new start is accepted in the same cycle done=1 (the unit is IDLE then).

## Structure
- Package `muldiv_pkg` holds:
  - funct constants (FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO, FN_MFHI=0x10, FN_MFLO=0x12)
  - the state enum {IDLE, CALC, FIN}
- Sub-module `muldivcore`: the iteration datapath (accumulator/remainder registers, one step per enable).
- The top level holds the FSM, the counter, sign handling and HI/LO.

## Test plan
- MULT opa=0xFFFFFFFD (-3), opb=5 -> 34 cycles later hi=0xFFFFFFFF, lo=0xFFFFFFF1; done high exactly one cycle; busy high 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> hi=7, lo=0xFFFFFFFF. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- MULT started, flush at cycle 10 -> busy=0 next cycle, hi/lo keep prior values, no done. A new DIVU issued that cycle completes correctly.
- MTHI 0x1234 while idle -> hi=0x1234 next cycle, busy=0. start with MTLO while busy -> ignored, lo unchanged at completion.
- rst_n low at cycle 20 of a MULT -> hi=lo=0, busy=0, done=0 immediately. After release the unit accepts a new start.
